// File: rtl/tri_host_driver.sv
// tri_host_driver: feeds one triangle to the rasterizer as a three-cycle vertex
// burst, then builds an 8x8 coverage bitmap from the points it returns. It
// reports completion with a done pulse and flags a start or run timeout on err.
module tri_host_driver #(
  parameter int START_TO = 4,
  parameter int RUN_TO   = 96
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tri_valid,
  output logic        tri_ready,
  input  logic [17:0] tri_data,
  output logic        nt,
  output logic [2:0]  xi,
  output logic [2:0]  yi,
  input  logic        busy,
  input  logic        po,
  input  logic [2:0]  xo,
  input  logic [2:0]  yo,
  output logic [63:0] bitmap,
  output logic [6:0]  pix_cnt,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    V1,
    V2,
    V3,
    WAIT_BUSY,
    COLLECT,
    DONE
  } state_t;

  localparam int CNT_MAX = (RUN_TO > START_TO) ? RUN_TO : START_TO;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic [11:0]     vtx23;
  logic            accept;
  logic            timeout;
  logic            hit;
  logic [5:0]      pt_idx;
  logic [2:0]      xi_next;
  logic [2:0]      yi_next;

  // tri_ready is only high while idle, so this is the single accept condition.
  assign accept = (state == IDLE) && tri_valid && tri_ready;
  assign pt_idx = {yo, xo};
  assign hit    = (state == COLLECT) && po;

  // Next-state logic; one counter serves both the start wait and the run limit,
  // and it restarts from zero whenever the state changes.
  always_comb begin
    next_state = state;
    cnt_next   = '0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) next_state = V1;
      end
      V1: next_state = V2;
      V2: next_state = V3;
      V3: next_state = WAIT_BUSY;
      WAIT_BUSY: begin
        if (busy) begin
          next_state = COLLECT;
        end else if (cnt == CW'(START_TO - 1)) begin
          next_state = DONE;
          timeout    = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      COLLECT: begin
        // The last point arrives with busy falling, so po is still recorded here.
        if (!busy) begin
          next_state = DONE;
        end else if (cnt == CW'(RUN_TO - 1)) begin
          next_state = DONE;
          timeout    = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Vertex selection for the burst; vertex 1 comes straight from the accepted word.
  always_comb begin
    xi_next = 3'd0;
    yi_next = 3'd0;
    case (next_state)
      V1: begin
        xi_next = tri_data[17:15];
        yi_next = tri_data[14:12];
      end
      V2: begin
        xi_next = vtx23[11:9];
        yi_next = vtx23[8:6];
      end
      V3: begin
        xi_next = vtx23[5:3];
        yi_next = vtx23[2:0];
      end
      default: begin
        xi_next = 3'd0;
        yi_next = 3'd0;
      end
    endcase
  end

  // State and shared wait/run counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Hold vertices 2 and 3 for the rest of the burst.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vtx23 <= 12'd0;
    end else if (accept) begin
      vtx23 <= tri_data[11:0];
    end
  end

  // Handshake and rasterizer-side outputs, registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tri_ready <= 1'b0;
      nt        <= 1'b0;
      xi        <= 3'd0;
      yi        <= 3'd0;
      done      <= 1'b0;
    end else begin
      tri_ready <= (next_state == IDLE);
      nt        <= (next_state == V1);
      xi        <= xi_next;
      yi        <= yi_next;
      done      <= (next_state == DONE);
    end
  end

  // Results: cleared on accept, accumulated in COLLECT, otherwise held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitmap  <= 64'd0;
      pix_cnt <= 7'd0;
      err     <= 1'b0;
    end else if (accept) begin
      bitmap  <= 64'd0;
      pix_cnt <= 7'd0;
      err     <= 1'b0;
    end else begin
      if (hit && !bitmap[pt_idx]) begin
        bitmap[pt_idx] <= 1'b1;
        pix_cnt        <= pix_cnt + 7'd1;
      end
      if (timeout) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tri_host_driver.sv
// Bench for tri_host_driver: drives triangles, acts as a scripted rasterizer and
// checks each finished job against a queue of expected results.
module tb_tri_host_driver;

  localparam int START_TO = 4;
  localparam int RUN_TO   = 96;

  typedef struct packed {
    logic [63:0] bitmap;
    logic [6:0]  pix_cnt;
    logic        err;
  } result_t;

  logic        clk;
  logic        reset;
  logic        tri_valid;
  logic        tri_ready;
  logic [17:0] tri_data;
  logic        nt;
  logic [2:0]  xi;
  logic [2:0]  yi;
  logic        busy;
  logic        po;
  logic [2:0]  xo;
  logic [2:0]  yo;
  logic [63:0] bitmap;
  logic [6:0]  pix_cnt;
  logic        done;
  logic        err;

  result_t     exp_q[$];
  logic [5:0]  pt_q[$];
  result_t     mon_exp;
  int          check_cnt = 0;
  int          pass_cnt  = 0;
  int          done_cnt  = 0;

  tri_host_driver #(.START_TO(START_TO), .RUN_TO(RUN_TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .tri_valid (tri_valid),
    .tri_ready (tri_ready),
    .tri_data  (tri_data),
    .nt        (nt),
    .xi        (xi),
    .yi        (yi),
    .busy      (busy),
    .po        (po),
    .xo        (xo),
    .yo        (yo),
    .bitmap    (bitmap),
    .pix_cnt   (pix_cnt),
    .done      (done),
    .err       (err)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected result of a job from the scripted point list; mode 1 is a start
  // timeout (no points taken), mode 2 is a run timeout.
  function automatic result_t modelJob(input int mode);
    result_t r;
    r = '0;
    if (mode != 1) begin
      foreach (pt_q[i]) begin
        if (!r.bitmap[pt_q[i]]) begin
          r.bitmap[pt_q[i]] = 1'b1;
          r.pix_cnt         = r.pix_cnt + 7'd1;
        end
      end
    end
    if (mode != 0) r.err = 1'b1;
    return r;
  endfunction

  // Offer a triangle, then follow the accept and the three-vertex burst.
  task automatic applyStimulus(input logic [17:0] data, input int mode, input bit push_exp,
                               input bit keep_valid, output int waited);
    waited    = 0;
    tri_valid = 1'b1;
    tri_data  = data;
    if (push_exp) exp_q.push_back(modelJob(mode));
    while (!tri_ready && waited < 10) begin
      tick();
      waited++;
    end
    checkOutput("accept_ready", 64'(tri_ready), 64'd1);
    tick();
    if (!keep_valid) tri_valid = 1'b0;
    checkOutput("v1_nt", 64'(nt), 64'd1);
    checkOutput("v1_xy", 64'({xi, yi}), 64'(data[17:12]));
    checkOutput("v1_ready_low", 64'(tri_ready), 64'd0);
    checkOutput("accept_clr_bitmap", bitmap, 64'd0);
    checkOutput("accept_clr_cnt", 64'(pix_cnt), 64'd0);
    checkOutput("accept_clr_err", 64'(err), 64'd0);
    tick();
    checkOutput("v2_nt", 64'(nt), 64'd0);
    checkOutput("v2_xy", 64'({xi, yi}), 64'(data[11:6]));
    tick();
    checkOutput("v3_xy", 64'({xi, yi}), 64'(data[5:0]));
    checkOutput("v3_ready_low", 64'(tri_ready), 64'd0);
    tick();
    checkOutput("wait_idle_bus", 64'({nt, xi, yi}), 64'd0);
  endtask

  // Scripted rasterizer, starting in the first WAIT_BUSY cycle; returns the
  // number of cycles until done is seen.
  task automatic serveJob(input int mode, output int n);
    n = 0;
    case (mode)
      0: begin
        busy = 1'b1;
        po   = 1'b0;
        tick();
        n++;
        foreach (pt_q[i]) begin
          busy     = (i != pt_q.size() - 1);
          po       = 1'b1;
          {yo, xo} = pt_q[i];
          tick();
          n++;
        end
        busy = 1'b0;
        po   = 1'b0;
        checkOutput("done_after_fall", 64'(done), 64'd1);
      end
      1: begin
        busy = 1'b0;
        po   = 1'b1;
        xo   = 3'd5;
        yo   = 3'd5;
        while (!done && n < START_TO + 10) begin
          tick();
          n++;
        end
        po = 1'b0;
        checkOutput("start_to_latency", 64'(n), 64'(START_TO));
      end
      default: begin
        busy = 1'b1;
        po   = 1'b1;
        xo   = 3'd1;
        yo   = 3'd1;
        while (!done && n < RUN_TO + 20) begin
          tick();
          n++;
        end
        busy = 1'b0;
        po   = 1'b0;
        checkOutput("run_to_latency", 64'(n), 64'(RUN_TO + 1));
      end
    endcase
  endtask

  // Scoreboard: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (reset && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 64'(done), 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("sb_bitmap", bitmap, mon_exp.bitmap);
        checkOutput("sb_pix_cnt", 64'(pix_cnt), 64'(mon_exp.pix_cnt));
        checkOutput("sb_err", 64'(err), 64'(mon_exp.err));
      end
    end
  end

  // Main sequence of jobs.
  initial begin
    int w;
    int n;
    int saved_done;
    reset     = 1'b0;
    tri_valid = 1'b0;
    tri_data  = 18'd0;
    busy      = 1'b0;
    po        = 1'b0;
    xo        = 3'd0;
    yo        = 3'd0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", 64'(tri_ready), 64'd0);
    checkOutput("rst_bus", 64'({nt, xi, yi}), 64'd0);
    checkOutput("rst_bitmap", bitmap, 64'd0);
    checkOutput("rst_cnt", 64'(pix_cnt), 64'd0);
    checkOutput("rst_done_err", 64'({done, err}), 64'd0);
    reset = 1'b1;
    tick();
    checkOutput("ready_after_reset", 64'(tri_ready), 64'd1);

    $display("[TB] normal job");
    pt_q = '{6'd0, {3'd2, 3'd3}, {3'd7, 3'd7}};
    applyStimulus({3'd1, 3'd0, 3'd5, 3'd0, 3'd5, 3'd4}, 0, 1'b1, 1'b0, w);
    serveJob(0, n);
    tick();
    checkOutput("normal_done_one_cycle", 64'(done), 64'd0);
    checkOutput("normal_ready_idle", 64'(tri_ready), 64'd1);
    checkOutput("normal_bitmap_hold", bitmap, 64'h8000_0000_0008_0001);
    checkOutput("normal_cnt_hold", 64'(pix_cnt), 64'd3);
    checkOutput("normal_err_hold", 64'(err), 64'd0);

    $display("[TB] duplicate points");
    pt_q = '{{3'd2, 3'd3}, {3'd2, 3'd3}, {3'd2, 3'd3}, {3'd2, 3'd4}};
    applyStimulus({3'd2, 3'd2, 3'd6, 3'd3, 3'd4, 3'd7}, 0, 1'b1, 1'b0, w);
    serveJob(0, n);
    tick();
    checkOutput("dup_bitmap_hold", bitmap, 64'h0000_0000_0018_0000);
    checkOutput("dup_cnt_hold", 64'(pix_cnt), 64'd2);

    $display("[TB] start timeout then back-to-back job");
    pt_q.delete();
    applyStimulus({3'd0, 3'd0, 3'd7, 3'd0, 3'd0, 3'd7}, 1, 1'b1, 1'b1, w);
    serveJob(1, n);
    checkOutput("b2b_ready_low_done", 64'(tri_ready), 64'd0);
    tri_data = {3'd3, 3'd1, 3'd4, 3'd6, 3'd2, 3'd5};
    tick();
    checkOutput("b2b_ready_idle", 64'(tri_ready), 64'd1);
    checkOutput("start_to_err_hold", 64'(err), 64'd1);
    checkOutput("start_to_bitmap_hold", bitmap, 64'd0);
    pt_q = '{{3'd2, 3'd3}, {3'd2, 3'd3}, {3'd2, 3'd3}, {3'd2, 3'd4}};
    applyStimulus({3'd3, 3'd1, 3'd4, 3'd6, 3'd2, 3'd5}, 0, 1'b1, 1'b0, w);
    checkOutput("b2b_accept_wait", 64'(w), 64'd0);
    serveJob(0, n);
    tick();
    checkOutput("b2b_cnt_hold", 64'(pix_cnt), 64'd2);

    $display("[TB] run timeout");
    pt_q = '{{3'd1, 3'd1}};
    applyStimulus({3'd6, 3'd6, 3'd1, 3'd2, 3'd3, 3'd4}, 2, 1'b1, 1'b0, w);
    serveJob(2, n);
    tick();
    checkOutput("run_to_err_hold", 64'(err), 64'd1);
    checkOutput("run_to_bitmap_hold", bitmap, 64'h200);
    checkOutput("run_to_cnt_hold", 64'(pix_cnt), 64'd1);

    $display("[TB] reset during collect");
    applyStimulus({3'd5, 3'd5, 3'd2, 3'd2, 3'd7, 3'd1}, 0, 1'b0, 1'b0, w);
    busy = 1'b1;
    tick();
    po = 1'b1;
    xo = 3'd3;
    yo = 3'd3;
    tick();
    checkOutput("mid_collect_cnt", 64'(pix_cnt), 64'd1);
    saved_done = done_cnt;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_bitmap", bitmap, 64'd0);
    checkOutput("async_rst_cnt", 64'(pix_cnt), 64'd0);
    checkOutput("async_rst_flags", 64'({tri_ready, nt, done, err}), 64'd0);
    busy = 1'b0;
    po   = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    checkOutput("rst_release_ready", 64'(tri_ready), 64'd1);
    tick();
    checkOutput("no_done_on_reset", 64'(done_cnt), 64'(saved_done));
    checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
